// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester single-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned MEM_LAT_DEF = 4;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
    typedef enum logic {GNT_IF, GNT_D} gnt_t;

endpackage

// File: rtl/mem_lat_cnt.sv
// Loadable down-counter: after a load, expired rises on the MEM_LAT-th enabled cycle.
module mem_lat_cnt
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(MEM_LAT - 1);
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = en && (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency memory port between fetch and data requesters.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is data-over-fetch priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              if_stall,
    output logic              d_stall
);

    arb_state_t        state, state_nxt;
    gnt_t              gnt, gnt_sel;
    logic              grant;
    logic              lat_wr;
    logic [WORD_W-1:0] lat_addr, lat_wdata;
    logic              lat_expired;

    assign grant = (state == IDLE) && (if_req || d_req);

    // gnt keeps the identity of the most recent grant, so it doubles as the last-grant record.
    always_comb begin
        gnt_sel = GNT_IF;
`ifdef MEM_ARB_RR_EN
        if (d_req && if_req) begin
            if (gnt == GNT_D) gnt_sel = GNT_IF;
            else              gnt_sel = GNT_D;
        end else if (d_req) begin
            gnt_sel = GNT_D;
        end
`else
        if (d_req) gnt_sel = GNT_D;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        if_done   = 1'b0;
        d_done    = 1'b0;
        case (state)
            IDLE:  if (if_req || d_req) state_nxt = ISSUE;
            ISSUE: begin
                mem_en    = 1'b1;
                mem_wr    = lat_wr;
                state_nxt = WAIT;
            end
            WAIT:  if (lat_expired) state_nxt = DONE;
            DONE:  begin
                if_done   = (gnt == GNT_IF);
                d_done    = (gnt == GNT_D);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= GNT_IF;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant) begin
            gnt <= gnt_sel;
            if (gnt_sel == GNT_D) begin
                lat_wr    <= d_wr;
                lat_addr  <= d_addr;
                lat_wdata <= d_wdata;
            end else begin
                lat_wr    <= 1'b0;
                lat_addr  <= if_addr;
                lat_wdata <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (state == WAIT && lat_expired) begin
            if (gnt == GNT_IF)  if_rdata <= mem_rdata;
            else if (!lat_wr)   d_rdata  <= mem_rdata;
        end
    end

    mem_lat_cnt #(.MEM_LAT(MEM_LAT)) u_lat_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state == ISSUE),
        .en      (state == WAIT),
        .expired (lat_expired)
    );

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign if_stall  = if_req & ~if_done;
    assign d_stall   = d_req & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: instance 0 runs MEM_LAT=4, instance 1 runs MEM_LAT=1.
module tb_mem_arbiter;

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          gap;
        bit          drop;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic        rst_n [2];
    logic        if_req [2], d_req [2], d_wr [2], if_done [2], d_done [2];
    logic        mem_en [2], mem_wr [2], if_stall [2], d_stall [2];
    logic [15:0] if_addr [2], d_addr [2], d_wdata [2], if_rdata [2], d_rdata [2];
    logic [15:0] mem_addr [2], mem_wdata [2], mem_rdata [2];

    txn_t exp_q [2][$];
    txn_t if_q  [2][$];
    txn_t d_q   [2][$];
    txn_t cur [2];
    bit   cur_valid [2];
    int   issue_cyc [2];
    int   last_issue [2];

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input int g, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL i%0d %s: actual=%h required=%h (t=%0t)", g, name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] memrd(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hA123 : ~a;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_i
        localparam int unsigned L = (g == 0) ? 4 : 1;
        int          pend_due = -1;
        logic [15:0] pend_data = '0;

        mem_arbiter #(.MEM_LAT(L)) dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_rdata  (if_rdata[g]),
            .if_done   (if_done[g]),
            .d_req     (d_req[g]),
            .d_wr      (d_wr[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_rdata   (d_rdata[g]),
            .d_done    (d_done[g]),
            .mem_en    (mem_en[g]),
            .mem_wr    (mem_wr[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .if_stall  (if_stall[g]),
            .d_stall   (d_stall[g])
        );

        // Memory data is valid only during cycle issue+L; other cycles carry junk.
        always @(posedge clk) begin
            #1;
            mem_rdata[g] = (cyc == pend_due) ? pend_data : (16'hDEAD ^ 16'(cyc));
        end

        always @(negedge clk) begin
            if (!rst_n[g]) begin
                cur_valid[g] = 1'b0;
                pend_due = -1;
            end
            chk("if_stall", g, 16'(if_stall[g]), 16'(if_req[g] & ~if_done[g]));
            chk("d_stall", g, 16'(d_stall[g]), 16'(d_req[g] & ~d_done[g]));
            if (mem_en[g]) begin
                if (exp_q[g].size() == 0 || cur_valid[g]) begin
                    chk("spurious_mem_en", g, 16'(mem_en[g]), 16'h0);
                end else begin
                    cur[g] = exp_q[g].pop_front();
                    cur_valid[g] = 1'b1;
                    chk("mem_wr", g, 16'(mem_wr[g]), 16'(cur[g].wr));
                    chk("mem_addr", g, mem_addr[g], cur[g].addr);
                    if (cur[g].wr) chk("mem_wdata", g, mem_wdata[g], cur[g].wdata);
                    if (cur[g].gap != 0) chk("issue_gap", g, 16'(cyc - last_issue[g]), 16'(cur[g].gap));
                    last_issue[g] = cyc;
                    issue_cyc[g]  = cyc;
                    pend_due  = cyc + L;
                    pend_data = memrd(mem_addr[g]);
                end
            end
            if (if_done[g] || d_done[g]) begin
                if (!cur_valid[g]) begin
                    chk("spurious_done", g, {14'h0, if_done[g], d_done[g]}, 16'h0);
                end else begin
                    chk("one_done", g, 16'(if_done[g] & d_done[g]), 16'h0);
                    chk("done_sel", g, 16'(d_done[g]), 16'(cur[g].is_d));
                    chk("done_cycle", g, 16'(cyc - issue_cyc[g]), 16'(L + 1));
                    chk("rdata", g, cur[g].is_d ? d_rdata[g] : if_rdata[g], cur[g].rdata);
                    cur_valid[g] = 1'b0;
                end
            end
        end

        initial run_port(g, 1'b0);
        initial run_port(g, 1'b1);
    end

    task automatic run_port(input int g, input bit is_d);
        txn_t t;
        int   n;
        bit   got;
        if (is_d) begin
            d_req[g] = 1'b0; d_wr[g] = 1'b0; d_addr[g] = '0; d_wdata[g] = '0;
        end else begin
            if_req[g] = 1'b0; if_addr[g] = '0;
        end
        forever begin
            @(posedge clk); #1;
            got = 1'b0;
            if (is_d && d_q[g].size() != 0) begin
                t = d_q[g].pop_front(); got = 1'b1;
            end else if (!is_d && if_q[g].size() != 0) begin
                t = if_q[g].pop_front(); got = 1'b1;
            end
            if (!got) begin
                if (is_d) d_req[g] = 1'b0;
                else      if_req[g] = 1'b0;
            end else begin
                if (is_d) begin
                    d_req[g] = 1'b1; d_wr[g] = t.wr; d_addr[g] = t.addr; d_wdata[g] = t.wdata;
                end else begin
                    if_req[g] = 1'b1; if_addr[g] = t.addr;
                end
                n = 0;
                forever begin
                    @(posedge clk); #1;
                    n++;
                    if (t.drop && n == 1) begin
                        d_req[g] = 1'b0; d_wr[g] = 1'b1; d_addr[g] = 16'hBEEF; d_wdata[g] = 16'h1234;
                    end
                    if (!rst_n[g]) begin
                        if (is_d) d_req[g] = 1'b0;
                        else      if_req[g] = 1'b0;
                        break;
                    end
                    if (is_d ? d_done[g] : if_done[g]) break;
                    if (n >= 100) begin
                        chk("done_timeout", g, 16'(n), 16'h0);
                        break;
                    end
                end
            end
        end
    endtask

    task automatic post(input int g, input bit is_d, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rdata, input int gap, input bit drop);
        txn_t t;
        t.is_d = is_d; t.wr = wr; t.addr = addr; t.wdata = wdata;
        t.rdata = rdata; t.gap = gap; t.drop = drop;
        exp_q[g].push_back(t);
        if (is_d) d_q[g].push_back(t);
        else      if_q[g].push_back(t);
    endtask

    task automatic wait_idle(input int g);
        int n = 0;
        while ((exp_q[g].size() != 0 || cur_valid[g] || if_q[g].size() != 0 || d_q[g].size() != 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pending_after_drain", g, 16'(exp_q[g].size() + int'(cur_valid[g])), 16'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("rst_mem_en", g, 16'(mem_en[g]), 16'h0);
            chk("rst_mem_addr", g, mem_addr[g], 16'h0);
            chk("rst_mem_wdata", g, mem_wdata[g], 16'h0);
            chk("rst_dones", g, {14'h0, if_done[g], d_done[g]}, 16'h0);
            chk("rst_if_rdata", g, if_rdata[g], 16'h0);
            chk("rst_d_rdata", g, d_rdata[g], 16'h0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single fetch.
        post(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA123, 0, 1'b0);
        wait_idle(0);

        // Simultaneous store and fetch: store first, fetch issues 7 cycles later; d_rdata untouched.
        post(0, 1'b1, 1'b1, 16'h0200, 16'h55AA, 16'h0000, 0, 1'b0);
        post(0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'hFFDF, 7, 1'b0);
        wait_idle(0);

        // Both requesters hold two requests each.
`ifdef MEM_ARB_RR_EN
        post(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hFFBF, 0, 1'b0);
        post(0, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'hFEFF, 7, 1'b0);
        post(0, 1'b1, 1'b0, 16'h0044, 16'h0000, 16'hFFBB, 7, 1'b0);
        post(0, 1'b0, 1'b0, 16'h0104, 16'h0000, 16'hFEFB, 7, 1'b0);
`else
        post(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hFFBF, 0, 1'b0);
        post(0, 1'b1, 1'b0, 16'h0044, 16'h0000, 16'hFFBB, 7, 1'b0);
        post(0, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'hFEFF, 7, 1'b0);
        post(0, 1'b0, 1'b0, 16'h0104, 16'h0000, 16'hFEFB, 7, 1'b0);
`endif
        wait_idle(0);

        // Reset during WAIT aborts the fetch.
        post(0, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'hFFCF, 0, 1'b0);
        n = 0;
        while (!cur_valid[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("issue_before_reset", 0, 16'(cur_valid[0]), 16'h1);
        @(posedge clk); #1;
        rst_n[0] = 1'b0;
        #1;
        chk("abort_mem_en", 0, 16'(mem_en[0]), 16'h0);
        chk("abort_dones", 0, {14'h0, if_done[0], d_done[0]}, 16'h0);
        chk("abort_if_rdata", 0, if_rdata[0], 16'h0);
        chk("abort_d_rdata", 0, d_rdata[0], 16'h0);
        chk("abort_mem_addr", 0, mem_addr[0], 16'h0);
        repeat (3) @(posedge clk);
        #1;
        exp_q[0].delete();
        rst_n[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        post(0, 1'b0, 1'b0, 16'h0050, 16'h0000, 16'hFFAF, 0, 1'b0);
        wait_idle(0);

        // MEM_LAT=1 back-to-back loads; the first drops req and scrambles its inputs after grant.
        post(1, 1'b1, 1'b0, 16'h0001, 16'h0000, 16'hFFFE, 0, 1'b1);
        post(1, 1'b1, 1'b0, 16'h0002, 16'h0000, 16'hFFFD, 4, 1'b0);
        wait_idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 4: fixed memory read latency in cycles; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 if_req  input  1  instruction-fetch request, held until if_done.
REQ-005 if_addr  input  16  fetch address.
REQ-006 if_rdata  output  16  fetched instruction; valid while if_done=1, held until next if_done.
REQ-007 if_done  output  1  one-cycle fetch completion pulse.
REQ-008 d_req  input  1  data request (control Mem_En), held until d_done.
REQ-009 d_wr  input  1  data write (control Mem_Wr); 0 = load.
REQ-010 d_addr  input  16  data address.
REQ-011 d_wdata  input  16  store data.
REQ-012 d_rdata  output  16  load data; valid while d_done=1, held until next load completes.
REQ-013 d_done  output  1  one-cycle data completion pulse.
REQ-014 mem_en  output  1  single-port memory access strobe, one cycle per access.
REQ-015 mem_wr  output  1  memory write enable, qualified by mem_en.
REQ-016 mem_addr  output  16  memory address, registered.
REQ-017 mem_wdata  output  16  memory write data, registered.
REQ-018 mem_rdata  input  16  memory read data, valid exactly MEM_LAT cycles after mem_en.
REQ-019 if_stall, d_stall  output  1 each  req & ~done, for pipeline stall.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-021 IDLE: if any req high, grant one requester, latch its addr/wdata/wr and its identity, go to ISSUE next cycle; otherwise stay.
REQ-022 Default arbitration SHALL be fixed priority, data over fetch.
REQ-023 ISSUE (cycle T): mem_en=1, mem_wr=latched wr (0 for fetch), mem_addr/mem_wdata driven from latched values; go to WAIT.
REQ-024 WAIT: latency counter counts to MEM_LAT; mem_rdata captured on the edge ending cycle T+MEM_LAT; go to DONE.
REQ-025 DONE (cycle T+MEM_LAT+1): granted requester's done=1 and its rdata valid; go to IDLE; next ISSUE earliest T+MEM_LAT+3.
REQ-026 Stores SHALL complete with the same timing as loads; d_rdata SHALL NOT change on a store.
REQ-027 Requester inputs changing after grant SHALL NOT affect the access in flight.
REQ-028 A req dropped mid-access SHALL still complete; done still pulses.
REQ-029 A req high in IDLE SHALL always be a new request; requesters deassert req in the cycle after done.
REQ-030 mem_en and both done signals SHALL be 0 outside ISSUE/DONE respectively; at most one done per cycle.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, all outputs 0 (rdata, mem_addr, mem_wdata = 16'h0000), counter 0, last-grant = fetch.
REQ-032 Reset mid-access SHALL abort it: no done pulse, no further mem_en.

Configuration
REQ-033 Macro MEM_ARB_RR_EN defined: when both req high in IDLE, grant the requester not granted last (last-grant register); single requests granted directly.
REQ-034 Macro undefined: fixed data-over-fetch priority; last-grant register absent.

Structure
REQ-035 Shared package mem_arb_pkg: FSM state enum, grant-id enum (GNT_IF, GNT_D), MEM_LAT default, 16-bit word width constant.
REQ-036 One sub-module mem_lat_cnt: loadable down-counter asserting expiry after MEM_LAT cycles.

Verification
REQ-037 MEM_LAT=4, fetch only, if_addr=16'h0010, mem_rdata=16'hA123 in T+4 -> mem_en at T, if_done and if_rdata=16'hA123 at T+5.
REQ-038 Both req same cycle, d_wr=1, d_addr=16'h0200, d_wdata=16'h55AA -> data issues first with mem_wr=1; d_done at T+5; fetch issues at T+7.
REQ-039 MEM_ARB_RR_EN, both req held continuously over 4 accesses -> grants alternate D, IF, D, IF.
REQ-040 rst_n pulsed low during WAIT -> mem_en, done, rdata 0 immediately; no done after release; next req serviced normally.
REQ-041 MEM_LAT=1, back-to-back loads 16'h0001, 16'h0002 -> d_done spaced exactly 4 cycles apart; d_addr change after grant ignored.
